data_mem_unit: RTL and testbench

DATA_MEM_UNIT -- requirements
Module: data_mem_unit

---
 rtl/data_mem_pkg.sv | 14 +
 rtl/data_mem_if.sv | 46 ++++
 rtl/data_mem_ram.sv | 40 ++++
 rtl/data_mem_unit.sv | 105 ++++++++++
 tb/tb_data_mem_unit.sv | 359 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_pkg.sv
// Shared constants and dump FSM state type for the data memory unit.
package data_mem_pkg;

    localparam int DEF_CORE_COUNT     = 4;
    localparam int DEF_REG_WIDTH      = 12;
    localparam int DEF_DATA_MEM_DEPTH = 4096;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } dump_state_t;

endpackage

// File: rtl/data_mem_if.sv
// Processor and dump-stream bus of the data memory unit.
// laneWrMask exists only when DATA_MEM_LANE_MASK_EN is defined.
interface data_mem_if #(
    parameter int CORE_COUNT     = data_mem_pkg::DEF_CORE_COUNT,
    parameter int REG_WIDTH      = data_mem_pkg::DEF_REG_WIDTH,
    parameter int DATA_MEM_DEPTH = data_mem_pkg::DEF_DATA_MEM_DEPTH
);
    localparam int ADDR_W = $clog2(DATA_MEM_DEPTH);
    localparam int WORD_W = CORE_COUNT * REG_WIDTH;

    logic [ADDR_W-1:0]     dataMemAddr;
    logic [WORD_W-1:0]     ProcessorDataOut;
    logic                  DataMemWrEn;
`ifdef DATA_MEM_LANE_MASK_EN
    logic [CORE_COUNT-1:0] laneWrMask;
`endif
    logic [WORD_W-1:0]     ProcessorDataIn;
    logic                  dumpStart;
    logic [ADDR_W-1:0]     dumpStartAddr;
    logic [ADDR_W-1:0]     dumpEndAddr;
    logic [WORD_W-1:0]     dumpData;
    logic                  dumpValid;
    logic                  dumpReady;
    logic                  dumpLast;
    logic                  dumpBusy;
    logic                  dumpDone;

    modport master (
`ifdef DATA_MEM_LANE_MASK_EN
        output laneWrMask,
`endif
        output dataMemAddr, ProcessorDataOut, DataMemWrEn,
        output dumpStart, dumpStartAddr, dumpEndAddr, dumpReady,
        input  ProcessorDataIn, dumpData, dumpValid, dumpLast, dumpBusy, dumpDone
    );

    modport slave (
`ifdef DATA_MEM_LANE_MASK_EN
        input  laneWrMask,
`endif
        input  dataMemAddr, ProcessorDataOut, DataMemWrEn,
        input  dumpStart, dumpStartAddr, dumpEndAddr, dumpReady,
        output ProcessorDataIn, dumpData, dumpValid, dumpLast, dumpBusy, dumpDone
    );

endinterface

// File: rtl/data_mem_ram.sv
// Lane-organised storage: one masked write port, two synchronous read ports.
// Only the read registers are reset; the array keeps its contents.
module data_mem_ram #(
    parameter int CORE_COUNT     = data_mem_pkg::DEF_CORE_COUNT,
    parameter int REG_WIDTH      = data_mem_pkg::DEF_REG_WIDTH,
    parameter int DATA_MEM_DEPTH = data_mem_pkg::DEF_DATA_MEM_DEPTH,
    localparam int ADDR_W        = $clog2(DATA_MEM_DEPTH)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 wr_en,
    input  logic [ADDR_W-1:0]                    wr_addr,
    input  logic [CORE_COUNT-1:0][REG_WIDTH-1:0] wr_data,
    input  logic [CORE_COUNT-1:0]                wr_mask,
    input  logic [ADDR_W-1:0]                    a_addr,
    output logic [CORE_COUNT-1:0][REG_WIDTH-1:0] a_q,
    input  logic                                 b_en,
    input  logic [ADDR_W-1:0]                    b_addr,
    output logic [CORE_COUNT-1:0][REG_WIDTH-1:0] b_q
);
    logic [CORE_COUNT-1:0][REG_WIDTH-1:0] mem [DATA_MEM_DEPTH];

    always_ff @(posedge clk) begin
        for (int k = 0; k < CORE_COUNT; k++) begin
            if (wr_en && wr_mask[k]) mem[wr_addr][k] <= wr_data[k];
        end
    end

    // Reads sample the array before this edge's write lands: read-old-data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) a_q <= '0;
        else     a_q <= mem[a_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       b_q <= '0;
        else if (b_en) b_q <= mem[b_addr];
    end

endmodule

// File: rtl/data_mem_unit.sv
// Data memory with a free-running processor port and an independent range-dump
// stream. Optional per-lane write mask enabled by DATA_MEM_LANE_MASK_EN.
module data_mem_unit
    import data_mem_pkg::*;
#(
    parameter int CORE_COUNT     = DEF_CORE_COUNT,
    parameter int REG_WIDTH      = DEF_REG_WIDTH,
    parameter int DATA_MEM_DEPTH = DEF_DATA_MEM_DEPTH
) (
    input logic       clk,
    input logic       rst,
    data_mem_if.slave bus
);
    localparam int ADDR_W = $clog2(DATA_MEM_DEPTH);

    dump_state_t           state;
    logic [ADDR_W-1:0]     rd_addr;
    logic [ADDR_W-1:0]     end_addr;
    logic                  valid, last, busy, done;
    logic                  finish, issue;
    logic [CORE_COUNT-1:0] wr_mask;

`ifdef DATA_MEM_LANE_MASK_EN
    assign wr_mask = bus.laneWrMask;
`else
    assign wr_mask = '1;
`endif

    // The dump read register doubles as the output beat, so a new read is only
    // issued when the output slot is empty or being drained this cycle.
    assign finish = valid && bus.dumpReady && last;
    assign issue  = (state == ST_RUN) && !finish && (!valid || bus.dumpReady);

    data_mem_ram #(
        .CORE_COUNT    (CORE_COUNT),
        .REG_WIDTH     (REG_WIDTH),
        .DATA_MEM_DEPTH(DATA_MEM_DEPTH)
    ) u_ram (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (bus.DataMemWrEn),
        .wr_addr(bus.dataMemAddr),
        .wr_data(bus.ProcessorDataOut),
        .wr_mask(wr_mask),
        .a_addr (bus.dataMemAddr),
        .a_q    (bus.ProcessorDataIn),
        .b_en   (issue),
        .b_addr (rd_addr),
        .b_q    (bus.dumpData)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            rd_addr  <= '0;
            end_addr <= '0;
            valid    <= 1'b0;
            last     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (bus.dumpStart) begin
                        if (bus.dumpStartAddr <= bus.dumpEndAddr) begin
                            state    <= ST_RUN;
                            rd_addr  <= bus.dumpStartAddr;
                            end_addr <= bus.dumpEndAddr;
                            busy     <= 1'b1;
                        end else begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (finish) begin
                        state <= ST_DONE;
                        valid <= 1'b0;
                        last  <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (issue) begin
                        valid <= 1'b1;
                        last  <= (rd_addr == end_addr);
                        // Hold at the end address so a range ending at the top word never wraps.
                        if (rd_addr != end_addr) rd_addr <= rd_addr + ADDR_W'(1);
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.dumpValid = valid;
    assign bus.dumpLast  = last;
    assign bus.dumpBusy  = busy;
    assign bus.dumpDone  = done;

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed bench for data_mem_unit: processor port, dump stream, reset, boundaries.
// Lane-mask scenario is compiled only when DATA_MEM_LANE_MASK_EN is defined.
module tb_data_mem_unit;

    localparam int CC = 4;
    localparam int RW = 12;
    localparam int DEPTH = 4096;
    localparam int AW = 12;
    localparam int WW = CC * RW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    data_mem_if #(.CORE_COUNT(CC), .REG_WIDTH(RW), .DATA_MEM_DEPTH(DEPTH)) bus ();

    data_mem_unit #(.CORE_COUNT(CC), .REG_WIDTH(RW), .DATA_MEM_DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Fill pattern: lane k of word a holds a + k*0x100 (mod 4096).
    function automatic logic [WW-1:0] pat(int a);
        logic [11:0] b;
        b = 12'(a);
        return {b + 12'h300, b + 12'h200, b + 12'h100, b};
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic mem_write(int a, logic [WW-1:0] d);
        bus.dataMemAddr      = AW'(a);
        bus.ProcessorDataOut = d;
        bus.DataMemWrEn      = 1'b1;
        cyc();
        bus.DataMemWrEn      = 1'b0;
    endtask

    task automatic start_dump(int s, int e);
        bus.dumpStartAddr = AW'(s);
        bus.dumpEndAddr   = AW'(e);
        bus.dumpStart     = 1'b1;
        cyc();
        bus.dumpStart     = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if (bus.ProcessorDataIn !== '0 || bus.dumpData !== '0 || bus.dumpValid !== 1'b0 ||
            bus.dumpLast !== 1'b0 || bus.dumpBusy !== 1'b0 || bus.dumpDone !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: pdi=%h data=%h v=%b l=%b b=%b d=%b, required all 0",
                     bus.ProcessorDataIn, bus.dumpData, bus.dumpValid, bus.dumpLast,
                     bus.dumpBusy, bus.dumpDone);
        end
    endtask

    task automatic test_rw();
        mem_write(5, 48'h123456789ABC);
        cyc();
        n_checks++;
        if (bus.ProcessorDataIn !== 48'h123456789ABC) begin
            n_fail++;
            $display("FAIL rw_read: got %h required %h", bus.ProcessorDataIn, 48'h123456789ABC);
        end
        // Same-edge write and read of address 5 returns the old word.
        mem_write(5, 48'hFEDCBA987654);
        n_checks++;
        if (bus.ProcessorDataIn !== 48'h123456789ABC) begin
            n_fail++;
            $display("FAIL rw_old_data: got %h required %h", bus.ProcessorDataIn, 48'h123456789ABC);
        end
        cyc();
        n_checks++;
        if (bus.ProcessorDataIn !== 48'hFEDCBA987654) begin
            n_fail++;
            $display("FAIL rw_new_data: got %h required %h", bus.ProcessorDataIn, 48'hFEDCBA987654);
        end
        mem_write(6, 48'h00000000CAFE);
        bus.dataMemAddr = AW'(5);
        cyc();
        n_checks++;
        if (bus.ProcessorDataIn !== 48'hFEDCBA987654) begin
            n_fail++;
            $display("FAIL rw_neighbor: got %h required %h", bus.ProcessorDataIn, 48'hFEDCBA987654);
        end
        bus.dataMemAddr = AW'(6);
        cyc();
        n_checks++;
        if (bus.ProcessorDataIn !== 48'h00000000CAFE) begin
            n_fail++;
            $display("FAIL rw_addr6: got %h required %h", bus.ProcessorDataIn, 48'h00000000CAFE);
        end
    endtask

    task automatic test_dump_basic();
        bus.dumpReady = 1'b1;
        start_dump(5, 8);
        n_checks++;
        if (bus.dumpBusy !== 1'b1 || bus.dumpValid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_busy: busy=%b valid=%b required busy=1 valid=0", bus.dumpBusy, bus.dumpValid);
        end
        for (int i = 0; i < 4; i++) begin
            cyc();
            n_checks++;
            if (bus.dumpValid !== 1'b1 || bus.dumpData !== pat(5 + i) || bus.dumpLast !== (i == 3)) begin
                n_fail++;
                $display("FAIL basic_beat%0d: v=%b data=%h last=%b required v=1 data=%h last=%b",
                         i, bus.dumpValid, bus.dumpData, bus.dumpLast, pat(5 + i), (i == 3));
            end
        end
        cyc();
        n_checks++;
        if (bus.dumpDone !== 1'b1 || bus.dumpBusy !== 1'b0 || bus.dumpValid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done: done=%b busy=%b v=%b required 1 0 0", bus.dumpDone, bus.dumpBusy, bus.dumpValid);
        end
        cyc();
        n_checks++;
        if (bus.dumpDone !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done_pulse: done=%b required 0", bus.dumpDone);
        end
    endtask

    task automatic test_backpressure();
        int  got;
        int  stalls;
        bit  seen_done;
        got = 0;
        stalls = 0;
        seen_done = 0;
        bus.dumpReady = 1'b1;
        start_dump(5, 8);
        for (int t = 0; t < 30 && !seen_done; t++) begin
            if (bus.dumpDone === 1'b1) begin
                seen_done = 1;
            end else begin
                if (bus.dumpValid === 1'b1) begin
                    if (got == 1 && stalls < 3) begin
                        bus.dumpReady = 1'b0;
                        stalls++;
                    end else begin
                        bus.dumpReady = 1'b1;
                    end
                    n_checks++;
                    if (bus.dumpData !== pat(5 + got) || bus.dumpLast !== (got == 3)) begin
                        n_fail++;
                        $display("FAIL bp_beat%0d: data=%h last=%b required data=%h last=%b",
                                 got, bus.dumpData, bus.dumpLast, pat(5 + got), (got == 3));
                    end
                    if (bus.dumpReady) got++;
                end else begin
                    bus.dumpReady = 1'b1;
                end
                cyc();
            end
        end
        bus.dumpReady = 1'b1;
        n_checks++;
        if (!seen_done || got != 4 || stalls != 3) begin
            n_fail++;
            $display("FAIL bp_count: done=%0d beats=%0d stalls=%0d required 1 4 3", seen_done, got, stalls);
        end
        cyc();
    endtask

    task automatic test_zero_beats();
        bus.dumpReady = 1'b1;
        start_dump(9, 8);
        n_checks++;
        if (bus.dumpDone !== 1'b1 || bus.dumpBusy !== 1'b0 || bus.dumpValid !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_done: done=%b busy=%b v=%b required 1 0 0", bus.dumpDone, bus.dumpBusy, bus.dumpValid);
        end
        cyc();
        n_checks++;
        if (bus.dumpDone !== 1'b0 || bus.dumpBusy !== 1'b0 || bus.dumpValid !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_after: done=%b busy=%b v=%b required 0 0 0", bus.dumpDone, bus.dumpBusy, bus.dumpValid);
        end
    endtask

    task automatic test_reset_mid_dump();
        bus.dumpReady = 1'b1;
        start_dump(5, 12);
        cyc();
        cyc();
        n_checks++;
        if (bus.dumpValid !== 1'b1 || bus.dumpData !== pat(6)) begin
            n_fail++;
            $display("FAIL rst_mid_beat2: v=%b data=%h required v=1 data=%h", bus.dumpValid, bus.dumpData, pat(6));
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.ProcessorDataIn !== '0 || bus.dumpData !== '0 || bus.dumpValid !== 1'b0 ||
            bus.dumpLast !== 1'b0 || bus.dumpBusy !== 1'b0 || bus.dumpDone !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_async: pdi=%h data=%h v=%b l=%b b=%b d=%b, required all 0",
                     bus.ProcessorDataIn, bus.dumpData, bus.dumpValid, bus.dumpLast,
                     bus.dumpBusy, bus.dumpDone);
        end
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_checks++;
            if (bus.dumpDone !== 1'b0 || bus.dumpValid !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_mid_hold%0d: done=%b v=%b required 0 0", i, bus.dumpDone, bus.dumpValid);
            end
        end
        rst = 1'b0;
        start_dump(9, 11);
        n_checks++;
        if (bus.dumpBusy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_restart_busy: busy=%b required 1", bus.dumpBusy);
        end
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_checks++;
            if (bus.dumpValid !== 1'b1 || bus.dumpData !== pat(9 + i) || bus.dumpLast !== (i == 2)) begin
                n_fail++;
                $display("FAIL rst_restart_beat%0d: v=%b data=%h last=%b required v=1 data=%h last=%b",
                         i, bus.dumpValid, bus.dumpData, bus.dumpLast, pat(9 + i), (i == 2));
            end
        end
        cyc();
        n_checks++;
        if (bus.dumpDone !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_restart_done: done=%b required 1", bus.dumpDone);
        end
        cyc();
    endtask

    task automatic test_boundary();
        mem_write(4094, pat(4094));
        mem_write(4095, pat(4095));
        bus.dumpReady     = 1'b1;
        bus.dumpStartAddr = AW'(4094);
        bus.dumpEndAddr   = AW'(4095);
        bus.dumpStart     = 1'b1;
        cyc();
        // A second request while running must be ignored.
        bus.dumpStartAddr = AW'(0);
        bus.dumpEndAddr   = AW'(0);
        for (int i = 0; i < 2; i++) begin
            cyc();
            n_checks++;
            if (bus.dumpValid !== 1'b1 || bus.dumpData !== pat(4094 + i) || bus.dumpLast !== (i == 1)) begin
                n_fail++;
                $display("FAIL top_beat%0d: v=%b data=%h last=%b required v=1 data=%h last=%b",
                         i, bus.dumpValid, bus.dumpData, bus.dumpLast, pat(4094 + i), (i == 1));
            end
        end
        bus.dumpStart = 1'b0;
        cyc();
        n_checks++;
        if (bus.dumpDone !== 1'b1 || bus.dumpBusy !== 1'b0 || bus.dumpValid !== 1'b0) begin
            n_fail++;
            $display("FAIL top_done: done=%b busy=%b v=%b required 1 0 0", bus.dumpDone, bus.dumpBusy, bus.dumpValid);
        end
        cyc();
        n_checks++;
        if (bus.dumpDone !== 1'b0 || bus.dumpBusy !== 1'b0 || bus.dumpValid !== 1'b0) begin
            n_fail++;
            $display("FAIL top_idle: done=%b busy=%b v=%b required 0 0 0", bus.dumpDone, bus.dumpBusy, bus.dumpValid);
        end
    endtask

    task automatic test_write_during_run();
        bus.dumpReady = 1'b1;
        start_dump(5, 8);
        mem_write(8, 48'hABCDEF012345);
        n_checks++;
        if (bus.dumpData !== pat(5)) begin
            n_fail++;
            $display("FAIL wr_run_beat0: data=%h required %h", bus.dumpData, pat(5));
        end
        cyc();
        n_checks++;
        if (bus.dumpData !== pat(6) || bus.ProcessorDataIn !== 48'hABCDEF012345) begin
            n_fail++;
            $display("FAIL wr_run_beat1: data=%h pdi=%h required data=%h pdi=%h",
                     bus.dumpData, bus.ProcessorDataIn, pat(6), 48'hABCDEF012345);
        end
        cyc();
        n_checks++;
        if (bus.dumpData !== pat(7)) begin
            n_fail++;
            $display("FAIL wr_run_beat2: data=%h required %h", bus.dumpData, pat(7));
        end
        cyc();
        n_checks++;
        if (bus.dumpData !== 48'hABCDEF012345 || bus.dumpLast !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_run_beat3: data=%h last=%b required data=%h last=1",
                     bus.dumpData, bus.dumpLast, 48'hABCDEF012345);
        end
        cyc();
        cyc();
    endtask

`ifdef DATA_MEM_LANE_MASK_EN
    task automatic test_lane_mask();
        bus.laneWrMask = '1;
        mem_write(20, '0);
        bus.laneWrMask = 4'b0101;
        mem_write(20, '1);
        bus.laneWrMask = '1;
        cyc();
        n_checks++;
        if (bus.ProcessorDataIn !== 48'h000FFF000FFF) begin
            n_fail++;
            $display("FAIL lane_mask: got %h required %h", bus.ProcessorDataIn, 48'h000FFF000FFF);
        end
    endtask
`endif

    initial begin
        bus.dataMemAddr      = '0;
        bus.ProcessorDataOut = '0;
        bus.DataMemWrEn      = 1'b0;
`ifdef DATA_MEM_LANE_MASK_EN
        bus.laneWrMask       = '1;
`endif
        bus.dumpStart        = 1'b0;
        bus.dumpStartAddr    = '0;
        bus.dumpEndAddr      = '0;
        bus.dumpReady        = 1'b0;
        cyc();
        cyc();
        test_reset();
        rst = 1'b0;
        cyc();
        test_rw();
        for (int a = 5; a <= 12; a++) mem_write(a, pat(a));
        test_dump_basic();
        test_backpressure();
        test_zero_beats();
        test_reset_mid_dump();
        test_boundary();
        test_write_during_run();
`ifdef DATA_MEM_LANE_MASK_EN
        test_lane_mask();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
